// File: rtl/zone_alarm_ctrl.sv
// Multi-zone alarm controller: entry delay, timed siren with silenced re-trigger, zone latching.
// Build option: define INSTANT_ZONE_EN to add i_instant_mask (zones that bypass the entry delay).
module zone_alarm_ctrl #(
    parameter int NUM_ZONES     = 4,
    parameter int ENTRY_DELAY   = 16,
    parameter int ALARM_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_arm,
    input  logic                 i_disarm,
    input  logic [NUM_ZONES-1:0] i_sensor,
    input  logic [NUM_ZONES-1:0] i_zone_mask,
`ifdef INSTANT_ZONE_EN
    input  logic [NUM_ZONES-1:0] i_instant_mask,
`endif
    output logic                 o_alarm,
    output logic [2:0]           o_state,
    output logic [NUM_ZONES-1:0] o_zone_latched,
    output logic                 o_arm_fail
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_ENTRY    = 3'd2,
        S_ALARM    = 3'd3,
        S_SILENCED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIMEOUT - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_ZONES-1:0] w_trip_vec;
    logic                 w_trip;
    logic                 w_instant;

    assign w_trip_vec = i_sensor & i_zone_mask;
    assign w_trip     = |w_trip_vec;
`ifdef INSTANT_ZONE_EN
    assign w_instant  = |(w_trip_vec & i_instant_mask);
`else
    assign w_instant  = 1'b0;
`endif

    assign o_state = r_state;

    // o_alarm is written alongside every state change so it always equals (state == ALARM).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_DISARMED;
            r_cnt          <= '0;
            o_alarm        <= 1'b0;
            o_zone_latched <= '0;
            o_arm_fail     <= 1'b0;
        end else begin
            o_arm_fail <= 1'b0;
            if (i_disarm) begin
                r_state        <= S_DISARMED;
                r_cnt          <= '0;
                o_alarm        <= 1'b0;
                o_zone_latched <= '0;
            end else begin
                case (r_state)
                    S_DISARMED: begin
                        o_alarm <= 1'b0;
                        if (i_arm && !w_trip) begin
                            r_state <= S_ARMED;
                        end else if (i_arm) begin
                            o_arm_fail <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        o_zone_latched <= o_zone_latched | w_trip_vec;
                        if (w_instant) begin
                            r_state <= S_ALARM;
                            r_cnt   <= ALARM_LOAD;
                            o_alarm <= 1'b1;
                        end else if (w_trip) begin
                            r_state <= S_ENTRY;
                            r_cnt   <= ENTRY_LOAD;
                            o_alarm <= 1'b0;
                        end else begin
                            o_alarm <= 1'b0;
                        end
                    end
                    S_ENTRY: begin
                        o_zone_latched <= o_zone_latched | w_trip_vec;
                        if (w_instant || r_cnt == '0) begin
                            r_state <= S_ALARM;
                            r_cnt   <= ALARM_LOAD;
                            o_alarm <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt - CNT_W'(1);
                            o_alarm <= 1'b0;
                        end
                    end
                    S_ALARM: begin
                        o_zone_latched <= o_zone_latched | w_trip_vec;
                        if (r_cnt == '0) begin
                            r_state <= S_SILENCED;
                            o_alarm <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt - CNT_W'(1);
                            o_alarm <= 1'b1;
                        end
                    end
                    S_SILENCED: begin
                        o_zone_latched <= o_zone_latched | w_trip_vec;
                        if (w_trip) begin
                            r_state <= S_ALARM;
                            r_cnt   <= ALARM_LOAD;
                            o_alarm <= 1'b1;
                        end else begin
                            o_alarm <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= S_DISARMED;
                        r_cnt          <= '0;
                        o_alarm        <= 1'b0;
                        o_zone_latched <= '0;
                    end
                endcase
            end
        end
    end

endmodule
